// File: rtl/regfile_bypass.sv
// regfile_bypass
//   Multi-port integer register file with a write-first bypass and a
//   pending-writeback scoreboard. It sits in front of the ALU operand mux and
//   raises HAZ when an operand's producing load has not yet written back.
//
// Ports
//   clk, rst_n   clock; asynchronous active-low reset
//   RA1, RA2     read addresses (register 0 always reads as zero)
//   RD1, RD2     combinational read data, with bypass of this cycle's write
//   WE, WA, WD   write port; a write also retires the pending bit of WA
//   ISSUE, IA    long-latency producer issuing to IA; marks IA pending
//   HAZ          a read operand is pending and not resolved by bypass
module regfile_bypass #(
   parameter int unsigned N  = 32,
   parameter int unsigned R  = 32,
   parameter int unsigned AW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] RA1,
   input  logic [AW-1:0] RA2,
   output logic [N-1:0]  RD1,
   output logic [N-1:0]  RD2,
   input  logic          WE,
   input  logic [AW-1:0] WA,
   input  logic [N-1:0]  WD,
   input  logic          ISSUE,
   input  logic [AW-1:0] IA,
   output logic          HAZ
);

   if (R != (1 << AW)) begin : g_bad_r
      $error("regfile_bypass: R must equal 2**AW");
   end

   logic [N-1:0] regs_q [R];
   logic [R-1:0] pend_q;
   logic [R-1:0] pend_d;

   logic wr_en;
   logic iss_en;
   logic byp1;
   logic byp2;
   logic h1;
   logic h2;

   assign wr_en  = WE && (WA != '0);
   assign iss_en = ISSUE && (IA != '0);

   // Same-cycle writeback to the read address bypasses the array.
   assign byp1 = WE && (WA == RA1);
   assign byp2 = WE && (WA == RA2);

   // Clear first, then set: a new producer on the retiring register wins.
   always_comb begin
      pend_d = pend_q;
      if (wr_en) begin
         pend_d[WA] = 1'b0;
      end
      if (iss_en) begin
         pend_d[IA] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(R); i++) begin
            regs_q[i] <= '0;
         end
         pend_q <= '0;
      end else begin
         if (wr_en) begin
            regs_q[WA] <= WD;
         end
         pend_q <= pend_d;
      end
   end

   // Reads are gated by rst_n so that a bypassed WD cannot leak out in reset.
   always_comb begin
      RD1 = '0;
      if (rst_n && (RA1 != '0)) begin
         RD1 = byp1 ? WD : regs_q[RA1];
      end
   end

   always_comb begin
      RD2 = '0;
      if (rst_n && (RA2 != '0)) begin
         RD2 = byp2 ? WD : regs_q[RA2];
      end
   end

   // Uses registered pend_q only; an ISSUE this cycle is not yet visible.
   assign h1  = (RA1 != '0) && pend_q[RA1] && !byp1;
   assign h2  = (RA2 != '0) && pend_q[RA2] && !byp2;
   assign HAZ = rst_n && (h1 || h2);

endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass
//   Directed-vector bench for regfile_bypass. Inputs change 1 time unit after
//   the rising edge; combinational outputs are checked 1 unit later.
module tb_regfile_bypass;

   logic        clk;
   logic        rst_n;
   logic [4:0]  RA1;
   logic [4:0]  RA2;
   logic [31:0] RD1;
   logic [31:0] RD2;
   logic        WE;
   logic [4:0]  WA;
   logic [31:0] WD;
   logic        ISSUE;
   logic [4:0]  IA;
   logic        HAZ;

   int checks;
   int errors;

   regfile_bypass #(
      .N  (32),
      .R  (32),
      .AW (5)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .RA1   (RA1),
      .RA2   (RA2),
      .RD1   (RD1),
      .RD2   (RD2),
      .WE    (WE),
      .WA    (WA),
      .WD    (WD),
      .ISSUE (ISSUE),
      .IA    (IA),
      .HAZ   (HAZ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      WE    = 1'b0;
      ISSUE = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      RA1    = '0;
      RA2    = '0;
      WE     = 1'b0;
      WA     = '0;
      WD     = '0;
      ISSUE  = 1'b0;
      IA     = '0;

      // 1. Reset: every address reads zero, no hazard.
      tick();
      tick();
      for (int a = 0; a < 32; a++) begin
         RA1 = 5'(a);
         RA2 = 5'(31 - a);
         #1;
         check($sformatf("rst_rd1_%0d", a), RD1, 32'h0);
         check($sformatf("rst_rd2_%0d", a), RD2, 32'h0);
         check($sformatf("rst_haz_%0d", a), {31'h0, HAZ}, 32'h0);
      end
      // Bypass must not leak through while in reset.
      WE  = 1'b1;
      WA  = 5'd5;
      WD  = 32'h1234_5678;
      RA1 = 5'd5;
      #1;
      check("rst_no_bypass", RD1, 32'h0);
      tick();
      WE = 1'b0;
      #1;
      check("rst_no_write", RD1, 32'h0);
      rst_n = 1'b1;
      #1;
      check("post_rst_rd1", RD1, 32'h0);

      // 2. Write/read, and writes to register 0 are ignored.
      WE = 1'b1;
      WA = 5'd5;
      WD = 32'hDEAD_BEEF;
      tick();
      idle();
      RA1 = 5'd5;
      #1;
      check("wr5_rd1", RD1, 32'hDEAD_BEEF);
      WE  = 1'b1;
      WA  = 5'd0;
      WD  = 32'hFFFF_FFFF;
      RA2 = 5'd0;
      #1;
      check("wr0_bypass_rd2", RD2, 32'h0);
      tick();
      idle();
      #1;
      check("wr0_rd2", RD2, 32'h0);

      // 3. Write-first bypass on both ports.
      WE = 1'b1;
      WA = 5'd7;
      WD = 32'h11;
      tick();
      WD  = 32'h22;
      RA1 = 5'd7;
      RA2 = 5'd7;
      #1;
      check("byp_rd1", RD1, 32'h22);
      check("byp_rd2", RD2, 32'h22);
      tick();
      idle();
      #1;
      check("after_byp_rd1", RD1, 32'h22);
      check("after_byp_rd2", RD2, 32'h22);

      // 4. Scoreboard set, visible only after the edge; writeback resolves it.
      ISSUE = 1'b1;
      IA    = 5'd9;
      RA1   = 5'd9;
      RA2   = 5'd0;
      #1;
      check("issue_not_visible", {31'h0, HAZ}, 32'h0);
      tick();
      idle();
      #1;
      check("pend9_haz", {31'h0, HAZ}, 32'h1);
      WE = 1'b1;
      WA = 5'd9;
      WD = 32'h55;
      #1;
      check("wb9_haz", {31'h0, HAZ}, 32'h0);
      check("wb9_rd1", RD1, 32'h55);
      tick();
      idle();
      #1;
      check("after_wb9_haz", {31'h0, HAZ}, 32'h0);
      check("after_wb9_rd1", RD1, 32'h55);

      // 5. Issue and write on the same register: set wins, data written.
      ISSUE = 1'b1;
      IA    = 5'd3;
      tick();
      WE  = 1'b1;
      WA  = 5'd3;
      WD  = 32'hA;
      RA1 = 5'd3;
      #1;
      check("same_cyc_haz", {31'h0, HAZ}, 32'h0);
      check("same_cyc_rd1", RD1, 32'hA);
      tick();
      idle();
      #1;
      check("set_wins_haz", {31'h0, HAZ}, 32'h1);
      check("set_wins_rd1", RD1, 32'hA);
      // Different addresses: both the clear and the set take effect.
      ISSUE = 1'b1;
      IA    = 5'd10;
      WE    = 1'b1;
      WA    = 5'd3;
      WD    = 32'hB;
      tick();
      idle();
      RA1 = 5'd3;
      RA2 = 5'd10;
      #1;
      check("diff_set_haz", {31'h0, HAZ}, 32'h1);
      RA2 = 5'd0;
      #1;
      check("diff_clr_haz", {31'h0, HAZ}, 32'h0);
      check("diff_rd1", RD1, 32'hB);
      WE = 1'b1;
      WA = 5'd10;
      WD = 32'h10;
      tick();
      idle();
      // Issue to register 0 never creates a hazard.
      ISSUE = 1'b1;
      IA    = 5'd0;
      tick();
      idle();
      RA1 = 5'd0;
      RA2 = 5'd0;
      #1;
      check("ia0_haz", {31'h0, HAZ}, 32'h0);

      // 6. Hazard on port 2 only.
      ISSUE = 1'b1;
      IA    = 5'd4;
      tick();
      idle();
      RA1 = 5'd2;
      RA2 = 5'd4;
      #1;
      check("p2_haz", {31'h0, HAZ}, 32'h1);
      check("p2_rd1", RD1, 32'h0);
      RA2 = 5'd6;
      #1;
      check("p2_clear_haz", {31'h0, HAZ}, 32'h0);

      // Mid-run reset clears contents and pending bits before any edge.
      RA1   = 5'd5;
      RA2   = 5'd4;
      #1;
      check("pre_rst_rd1", RD1, 32'hDEAD_BEEF);
      check("pre_rst_haz", {31'h0, HAZ}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rd1", RD1, 32'h0);
      check("mid_rst_haz", {31'h0, HAZ}, 32'h0);
      RA1 = 5'd7;
      #1;
      check("mid_rst_rd7", RD1, 32'h0);
      tick();
      rst_n = 1'b1;
      #1;
      check("rel_rst_rd7", RD1, 32'h0);
      check("rel_rst_haz", {31'h0, HAZ}, 32'h0);
      RA1 = 5'd5;
      #1;
      check("rel_rst_rd5", RD1, 32'h0);
      tick();
      #1;
      check("rel_rst_edge_haz", {31'h0, HAZ}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
